// File: rtl/action_out_merge_pkg.sv
// Shared action-engine definitions: merge FSM states, discard flag position,
// and the PHV width helper used by the merge stage ports.
package action_out_merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_META = 2'd1,
        ST_WAIT_CONT = 2'd2,
        ST_OUTPUT    = 2'd3
    } merge_state_t;

    localparam int DISCARD_BIT = 128;
    localparam int CNT_W       = 16;

    function automatic int phv_width(input int n_cont, input int cont_len, input int meta_len);
        return n_cont * cont_len + meta_len;
    endfunction

endpackage

// File: rtl/action_out_merge_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16
    import action_out_merge_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/action_out_merge.sv
// Joins the metadata half and the container half of a PHV into one registered
// output beat, dropping halves whose partner does not arrive within TIMEOUT cycles.
module action_out_merge
    import action_out_merge_pkg::*;
#(
    parameter int STAGE_ID = 0,
    parameter int CONT_LEN = 32,
    parameter int N_CONT   = 8,
    parameter int META_LEN = 256,
    parameter int TIMEOUT  = 15
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [META_LEN-1:0]                               comp_meta_data_in,
    input  logic                                              comp_meta_data_valid_in,
    input  logic [N_CONT*CONT_LEN-1:0]                        cont_data_in,
    input  logic                                              cont_valid_in,
    output logic                                              merge_ready_out,
    output logic [phv_width(N_CONT, CONT_LEN, META_LEN)-1:0] phv_out,
    output logic                                              phv_valid_out,
    input  logic                                              phv_ready_in,
    output logic [CNT_W-1:0]                                  drop_cnt,
    output logic [CNT_W-1:0]                                  discard_cnt,
    output logic                                              proto_err
);

    localparam int CONT_W = N_CONT * CONT_LEN;
    localparam int PHV_W  = phv_width(N_CONT, CONT_LEN, META_LEN);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    if (TIMEOUT < 1 || META_LEN <= DISCARD_BIT || STAGE_ID < 0) begin : g_param_check
        $error("action_out_merge: invalid parameter set");
    end

    merge_state_t       r_state;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic [META_LEN-1:0] r_meta;
    logic [CONT_W-1:0]  r_cont;
    logic [PHV_W-1:0]   r_phv;
    logic               r_valid;
    logic               r_proto_err;

    logic                w_waiting;
    logic                w_complete;
    logic                w_timeout;
    logic                w_discard;
    logic [META_LEN-1:0] w_meta_sel;
    logic [CONT_W-1:0]   w_cont_sel;

    // The half already held in a WAIT state comes from its register, the other from the port.
    assign w_meta_sel = (r_state == ST_WAIT_CONT) ? r_meta : comp_meta_data_in;
    assign w_cont_sel = (r_state == ST_WAIT_META) ? r_cont : cont_data_in;

    assign w_waiting  = (r_state == ST_WAIT_META) || (r_state == ST_WAIT_CONT);
    assign w_complete = ((r_state == ST_IDLE) && comp_meta_data_valid_in && cont_valid_in)
                     || ((r_state == ST_WAIT_META) && comp_meta_data_valid_in)
                     || ((r_state == ST_WAIT_CONT) && cont_valid_in);
    // A completing strobe on the last wait cycle beats the timeout.
    assign w_timeout  = w_waiting && (r_wait_cnt == WAIT_LAST) && !w_complete;
    assign w_discard  = (r_state == ST_OUTPUT) && !r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_meta      <= '0;
            r_cont      <= '0;
            r_phv       <= '0;
            r_valid     <= 1'b0;
            r_proto_err <= 1'b0;
        end else if (w_complete) begin
            r_meta     <= w_meta_sel;
            r_cont     <= w_cont_sel;
            r_wait_cnt <= '0;
            r_state    <= ST_OUTPUT;
            if (!w_meta_sel[DISCARD_BIT]) begin
                r_phv   <= {w_cont_sel, w_meta_sel};
                r_valid <= 1'b1;
            end
            if ((r_state == ST_WAIT_META && cont_valid_in)
                || (r_state == ST_WAIT_CONT && comp_meta_data_valid_in)) begin
                r_proto_err <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wait_cnt <= '0;
                    if (cont_valid_in) begin
                        r_cont  <= cont_data_in;
                        r_state <= ST_WAIT_META;
                    end else if (comp_meta_data_valid_in) begin
                        r_meta  <= comp_meta_data_in;
                        r_state <= ST_WAIT_CONT;
                    end
                end
                ST_WAIT_META, ST_WAIT_CONT: begin
                    if (cont_valid_in || comp_meta_data_valid_in) begin
                        r_proto_err <= 1'b1;
                    end
                    if (w_timeout) begin
                        r_meta     <= '0;
                        r_cont     <= '0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (cont_valid_in || comp_meta_data_valid_in) begin
                        r_proto_err <= 1'b1;
                    end
                    if (!r_valid) begin
                        r_state <= ST_IDLE;
                    end else if (phv_ready_in) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sat_cnt16 u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_timeout),
        .o_cnt (drop_cnt)
    );

    sat_cnt16 u_discard_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_discard),
        .o_cnt (discard_cnt)
    );

    assign merge_ready_out = (r_state != ST_OUTPUT);
    assign phv_out         = r_phv;
    assign phv_valid_out   = r_valid;
    assign proto_err       = r_proto_err;

endmodule

// File: tb/tb_action_out_merge.sv
// Randomized transaction bench for action_out_merge with a per-transaction
// reference model of join, timeout, discard and protocol-error behaviour.
module tb_action_out_merge;

    localparam int CL      = 32;
    localparam int NC      = 8;
    localparam int MW      = 256;
    localparam int TIMEOUT = 15;
    localparam int CW      = NC * CL;
    localparam int PW      = CW + MW;
    localparam int DISC    = 128;

    logic          clk;
    logic          rst_n;
    logic [MW-1:0] meta_in;
    logic          meta_v;
    logic [CW-1:0] cont_in;
    logic          cont_v;
    logic          merge_ready;
    logic [PW-1:0] phv_out;
    logic          phv_valid;
    logic          phv_ready;
    logic [15:0]   drop_cnt;
    logic [15:0]   discard_cnt;
    logic          proto_err;

    int            n_checks;
    int            n_errors;
    int            exp_drop;
    int            exp_discard;
    bit            exp_proto;
    logic [PW-1:0] last_phv;

    action_out_merge #(
        .STAGE_ID (0),
        .CONT_LEN (CL),
        .N_CONT   (NC),
        .META_LEN (MW),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .comp_meta_data_in       (meta_in),
        .comp_meta_data_valid_in (meta_v),
        .cont_data_in            (cont_in),
        .cont_valid_in           (cont_v),
        .merge_ready_out         (merge_ready),
        .phv_out                 (phv_out),
        .phv_valid_out           (phv_valid),
        .phv_ready_in            (phv_ready),
        .drop_cnt                (drop_cnt),
        .discard_cnt             (discard_cnt),
        .proto_err               (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        meta_v = 1'b0;
        cont_v = 1'b0;
    endtask

    task automatic check_cnts(input string tag);
        chk({tag, "_drop"},    PW'(drop_cnt),    PW'(exp_drop));
        chk({tag, "_discard"}, PW'(discard_cnt), PW'(exp_discard));
        chk({tag, "_proto"},   PW'(proto_err),   PW'(exp_proto));
    endtask

    task automatic check_static(input string tag);
        check_cnts(tag);
        chk({tag, "_phv_hold"}, phv_out, last_phv);
    endtask

    task automatic drive_half(input bit is_cont, input logic [MW-1:0] m, input logic [CW-1:0] c);
        if (is_cont) begin
            cont_in = c;
            cont_v  = 1'b1;
        end else begin
            meta_in = m;
            meta_v  = 1'b1;
        end
    endtask

    function automatic logic [MW-1:0] rand_meta(input bit disc);
        logic [MW-1:0] r;
        for (int i = 0; i < MW / 32; i++) r[i*32 +: 32] = $urandom;
        r[DISC] = disc;
        return r;
    endfunction

    function automatic logic [CW-1:0] rand_cont();
        logic [CW-1:0] r;
        for (int i = 0; i < NC; i++) r[i*CL +: CL] = $urandom;
        return r;
    endfunction

    // gap: cycles from first half to second (0 = same cycle, > TIMEOUT = never sent).
    // mode: 0 clean, 1 repeat held half during wait, 2 extra strobe while in OUTPUT.
    task automatic run_txn(input logic [MW-1:0] m, input logic [CW-1:0] c, input bit cont_first,
                           input int gap, input int stall, input int mode);
        logic [PW-1:0] exp_phv;
        bit            disc;
        disc    = m[DISC];
        exp_phv = {c, m};
        chk("rdy_idle", PW'(merge_ready), PW'(1));
        check_static("pre");
        if (gap == 0) begin
            drive_half(1'b1, m, c);
            drive_half(1'b0, m, c);
            step();
            clr();
        end else begin
            drive_half(cont_first, m, c);
            step();
            clr();
            for (int k = 1; k <= TIMEOUT; k++) begin
                chk("rdy_wait", PW'(merge_ready), PW'(1));
                chk("vld_wait", PW'(phv_valid), PW'(0));
                check_static("wait");
                if (k == gap) begin
                    drive_half(!cont_first, m, c);
                end else if (mode == 1 && k == 1) begin
                    drive_half(cont_first, ~m, ~c);
                    exp_proto = 1'b1;
                end
                step();
                clr();
                if (k == gap) break;
            end
            if (gap > TIMEOUT) begin
                exp_drop++;
                chk("vld_drop", PW'(phv_valid), PW'(0));
                chk("rdy_drop", PW'(merge_ready), PW'(1));
                check_static("drop");
                return;
            end
        end
        if (disc) begin
            chk("vld_disc", PW'(phv_valid), PW'(0));
            chk("rdy_disc", PW'(merge_ready), PW'(0));
            check_static("disc_out");
            if (mode == 2) begin
                drive_half(1'b0, ~m, c);
                exp_proto = 1'b1;
            end
            step();
            clr();
            exp_discard++;
            chk("vld_after_disc", PW'(phv_valid), PW'(0));
            chk("rdy_after_disc", PW'(merge_ready), PW'(1));
            check_static("after_disc");
        end else begin
            for (int s = 0; s <= stall; s++) begin
                phv_ready = (s == stall);
                chk("vld_out", PW'(phv_valid), PW'(1));
                chk("phv_out", phv_out, exp_phv);
                chk("rdy_out", PW'(merge_ready), PW'(0));
                check_cnts("out");
                if (mode == 2 && s == 0) begin
                    drive_half(1'b0, ~m, c);
                    exp_proto = 1'b1;
                end
                step();
                clr();
            end
            phv_ready = 1'b1;
            last_phv  = exp_phv;
            chk("vld_end", PW'(phv_valid), PW'(0));
            chk("rdy_end", PW'(merge_ready), PW'(1));
            check_static("end");
        end
    endtask

    task automatic model_reset();
        exp_drop    = 0;
        exp_discard = 0;
        exp_proto   = 1'b0;
        last_phv    = '0;
    endtask

    initial begin
        logic [MW-1:0] m;
        logic [CW-1:0] c;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        meta_in   = '0;
        cont_in   = '0;
        meta_v    = 1'b0;
        cont_v    = 1'b0;
        phv_ready = 1'b1;
        model_reset();
        step();
        step();
        chk("rst_vld", PW'(phv_valid), PW'(0));
        chk("rst_rdy", PW'(merge_ready), PW'(1));
        check_static("rst");
        rst_n = 1'b1;
        step();

        // both halves together, metadata 1, lanes 1..8
        m = '0;
        m[0] = 1'b1;
        for (int i = 0; i < NC; i++) c[i*CL +: CL] = CL'(i + 1);
        run_txn(m, c, 1'b1, 0, 0, 0);
        step();

        // containers first, metadata three cycles later
        run_txn(rand_meta(1'b0), rand_cont(), 1'b1, 3, 0, 0);
        // containers alone: timeout drop
        run_txn(rand_meta(1'b0), rand_cont(), 1'b1, TIMEOUT + 1, 0, 0);
        // partner arrives on the final wait cycle: completion wins
        run_txn(rand_meta(1'b0), rand_cont(), 1'b0, TIMEOUT, 1, 0);
        // discard flag set
        run_txn(rand_meta(1'b1), rand_cont(), 1'b1, 0, 0, 0);
        // downstream stalls five cycles with an extra metadata strobe in OUTPUT
        run_txn(rand_meta(1'b0), rand_cont(), 1'b1, 0, 5, 2);

        // reset while containers are held
        drive_half(1'b1, m, rand_cont());
        step();
        clr();
        step();
        rst_n = 1'b0;
        step();
        model_reset();
        chk("midrst_vld", PW'(phv_valid), PW'(0));
        chk("midrst_rdy", PW'(merge_ready), PW'(1));
        check_static("midrst");
        rst_n = 1'b1;
        step();
        run_txn(rand_meta(1'b0), rand_cont(), 1'b0, 3, 0, 0);

        for (int t = 0; t < 40; t++) begin
            int mode;
            mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_txn(rand_meta($urandom_range(0, 3) == 0), rand_cont(), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, TIMEOUT + 2)), int'($urandom_range(0, 3)), mode);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                step();
                check_static("gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
